// File: rtl/serial_mac_unit.sv
// Serial-load unsigned multiply-accumulate unit.
// Operands shift in LSB first; product is added to or loaded into acc.
module serial_mac_unit #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 2*WIDTH+4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 acc_en,
  input  logic                 clear,
  input  logic                 a_ser,
  input  logic                 b_ser,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2*WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MUL,
    ACC
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [CW-1:0]    cnt;
  logic             acc_en_q;
  logic [PW-1:0]    mul;
  logic [ACC_WIDTH:0] sum;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH-1));
  assign busy     = (state != IDLE);

  assign mul = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
  assign sum = {1'b0, acc}
             + {{(ACC_WIDTH+1-PW){1'b0}}, prod};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start)    state_nx = LOAD;
      LOAD: if (last_bit) state_nx = MUL;
      MUL:                state_nx = ACC;
      ACC:                state_nx = IDLE;
      default:            state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      acc_en_q <= 1'b0;
      prod     <= '0;
      acc      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clear) begin
            acc      <= '0;
            overflow <= 1'b0;
          end
          if (start) begin
            acc_en_q <= acc_en;
            cnt      <= '0;
          end
        end
        LOAD: begin
          a_reg <= {a_ser, a_reg[WIDTH-1:1]};
          b_reg <= {b_ser, b_reg[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
        end
        MUL: prod <= mul;
        ACC: begin
          // Product always fits in acc, so only the add path can carry out.
          if (acc_en_q) begin
            acc <= sum[ACC_WIDTH-1:0];
            if (sum[ACC_WIDTH]) overflow <= 1'b1;
          end else begin
            acc <= {{(ACC_WIDTH-PW){1'b0}}, prod};
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
